// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the RISC-V immediate extender/encoder pair.
package riscv_imm_pkg;

    localparam int unsigned IMM_W   = 32;
    localparam int unsigned INSTR_W = 25;

    // ImmSrc format encodings
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Encodable signed ranges per format (B/J additionally require an even value)
    localparam int IS_MIN = -2048;
    localparam int IS_MAX = 2047;
    localparam int B_MIN  = -4096;
    localparam int B_MAX  = 4094;
    localparam int J_MIN  = -1048576;
    localparam int J_MAX  = 1048574;

    // One buffered encoder result
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               err;
    } enc_entry_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder.
interface imm_encoder_if;
    import riscv_imm_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [IMM_W-1:0]   imm;
    logic [1:0]         ImmSrc;
    logic [INSTR_W-1:0] templ;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic               out_err;

    modport master (
        output in_valid, imm, ImmSrc, templ, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, imm, ImmSrc, templ, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/imm_pack.sv
// Scatters an immediate into instruction bits [31:7] and flags unencodable values.
module imm_pack
    import riscv_imm_pkg::*;
(
    input  logic [IMM_W-1:0]   imm,
    input  logic [1:0]         imm_src,
    input  logic [INSTR_W-1:0] templ,
    output logic [INSTR_W-1:0] instr_c,
    output logic               err_c
);

    // Index k here corresponds to instruction bit k+7.
    always_comb begin
        instr_c = templ;
        err_c   = 1'b0;
        case (imm_src)
            IMM_I: begin
                instr_c[24:13] = imm[11:0];
                err_c = ($signed(imm) < IS_MIN) || ($signed(imm) > IS_MAX);
            end
            IMM_S: begin
                instr_c[24:18] = imm[11:5];
                instr_c[4:0]   = imm[4:0];
                err_c = ($signed(imm) < IS_MIN) || ($signed(imm) > IS_MAX);
            end
            IMM_B: begin
                instr_c[24]    = imm[12];
                instr_c[23:18] = imm[10:5];
                instr_c[4:1]   = imm[4:1];
                instr_c[0]     = imm[11];
                err_c = ($signed(imm) < B_MIN) || ($signed(imm) > B_MAX) || imm[0];
            end
            default: begin
                instr_c[24]    = imm[20];
                instr_c[23:14] = imm[10:1];
                instr_c[13]    = imm[11];
                instr_c[12:5]  = imm[19:12];
                err_c = ($signed(imm) < J_MIN) || ($signed(imm) > J_MAX) || imm[0];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packing stage, 2-entry output FIFO and saturating statistics.
module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_encoder_if.slave     bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    logic [INSTR_W-1:0] pack_instr;
    logic               pack_err;
    enc_entry_t         new_entry;

    enc_entry_t         head_q, head_d;
    enc_entry_t         tail_q, tail_d;
    logic [1:0]         occ_q, occ_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   enc_count_q, enc_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               push, pop;

    imm_pack u_pack (
        .imm     (bus.imm),
        .imm_src (bus.ImmSrc),
        .templ   (bus.templ),
        .instr_c (pack_instr),
        .err_c   (pack_err)
    );

    assign new_entry = '{instr: pack_instr, err: pack_err};
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid_q & bus.out_ready;

    // FIFO next state: head is the visible entry, tail only holds the second word
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = new_entry;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    tail_d = new_entry;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
        endcase
        out_valid_d = (occ_d != 2'd0);
        in_ready_d  = (occ_d != 2'd2);
    end

    // Saturating counters; clear wins over a same-cycle increment
    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (clr_cnt) begin
            enc_count_d = '0;
            err_count_d = '0;
        end else if (push) begin
            if (enc_count_q != '1) enc_count_d = enc_count_q + CNT_W'(1);
            if (pack_err && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = head_q.instr;
    assign bus.out_err   = head_q.err;
    assign enc_count     = enc_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, scoreboard and handshake corner cases.
module tb_imm_encoder;
    import riscv_imm_pkg::*;

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  src;
        logic [24:0] templ;
        logic [24:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [24:0] instr;
        logic        err;
        logic [1:0]  src;
        logic [31:0] imm;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    imm_encoder_if bus ();

    imm_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .clr_cnt   (clr_cnt),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pop_cnt = 0;
    vec_t vec [15];
    sb_t  sbq [$];
    sb_t  drv;

    // Reference extender: recovers the immediate from packed instruction bits
    function automatic logic [31:0] ext(input logic [24:0] i, input logic [1:0] s);
        case (s)
            2'b00:   ext = {{20{i[24]}}, i[24:13]};
            2'b01:   ext = {{20{i[24]}}, i[24:18], i[4:0]};
            2'b10:   ext = {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
            default: ext = {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected entry queued on accept, compared on pop
    always @(negedge clk) begin : monitor
        sb_t e;
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) sbq.push_back(drv);
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_pop: got word %0h, expected none", bus.out_instr);
                end else begin
                    e = sbq.pop_front();
                    check("sb_instr", 32'(bus.out_instr), 32'(e.instr));
                    check("sb_err", 32'(bus.out_err), 32'(e.err));
                    if (!e.err) check("roundtrip", ext(bus.out_instr, e.src), e.imm);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.imm      = v.imm;
        bus.ImmSrc   = v.src;
        bus.templ    = v.templ;
        drv = '{instr: v.exp_instr, err: v.exp_err, src: v.src, imm: v.imm};
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input vec_t v, output int stalls);
        drive(v);
        stalls = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
        bus.in_valid = 1'b0;
    endtask

    task automatic stream(input int first, input int last, output int total_stalls);
        int s;
        total_stalls = 0;
        for (int i = first; i <= last; i++) begin
            send(vec[i], s);
            total_stalls += s;
        end
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        int stalls;
        int p0;
        logic c_acc;

        // imm, src, templ, expected instr[31:7], expected err
        vec[0]  = '{32'hFFFFFFFF, IMM_I, 25'h0000000, 25'h1FFE000, 1'b0};
        vec[1]  = '{32'h000007FF, IMM_I, 25'h1FFFFFF, 25'h0FFFFFF, 1'b0};
        vec[2]  = '{32'h00000800, IMM_I, 25'h0000000, 25'h1000000, 1'b1};
        vec[3]  = '{32'hFFFFF800, IMM_I, 25'h0000000, 25'h1000000, 1'b0};
        vec[4]  = '{32'hFFFFF7FF, IMM_S, 25'h0000000, 25'h0FC001F, 1'b1};
        vec[5]  = '{32'h00000123, IMM_S, 25'h1FFFFFF, 25'h027FFE3, 1'b0};
        vec[6]  = '{32'hFFFFF000, IMM_B, 25'h0000000, 25'h1000000, 1'b0};
        vec[7]  = '{32'h00000003, IMM_B, 25'h0000000, 25'h0000002, 1'b1};
        vec[8]  = '{32'h00000FFE, IMM_B, 25'h0000000, 25'h0FC001F, 1'b0};
        vec[9]  = '{32'h00001000, IMM_B, 25'h0000000, 25'h1000000, 1'b1};
        vec[10] = '{32'h00100000, IMM_J, 25'h0000000, 25'h1000000, 1'b1};
        vec[11] = '{32'h000FFFFE, IMM_J, 25'h0000000, 25'h0FFFFE0, 1'b0};
        vec[12] = '{32'hFFFFFFFE, IMM_J, 25'h000001F, 25'h1FFFFFF, 1'b0};
        vec[13] = '{32'h00000005, IMM_J, 25'h0000000, 25'h0008000, 1'b1};
        vec[14] = '{32'h00000000, IMM_I, 25'h1555555, 25'h0001555, 1'b0};

        bus.in_valid  = 1'b0;
        bus.imm       = '0;
        bus.ImmSrc    = IMM_I;
        bus.templ     = '0;
        bus.out_ready = 1'b0;
        drv = '{instr: '0, err: 1'b0, src: 2'b00, imm: '0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", 32'(bus.out_instr), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // First-word latency: visible the cycle after acceptance
        bus.out_ready = 1'b1;
        p0 = pop_cnt;
        send(vec[0], stalls);
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_out_instr", 32'(bus.out_instr), 32'(vec[0].exp_instr));
        @(posedge clk);
        #1;
        check("lat_pops", 32'(pop_cnt - p0), 32'd1);
        check("lat_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back 10 with out_ready=1: no stalls, one pop per cycle
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        p0 = pop_cnt;
        stream(0, 9, stalls);
        check("b2b_stalls", 32'(stalls), 32'd0);
        check("b2b_enc_count", 32'(enc_count), 32'd10);
        check("b2b_err_count", 32'(err_count), 32'd4);
        @(posedge clk);
        #1;
        check("b2b_pops", 32'(pop_cnt - p0), 32'd10);
        check("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Remaining vectors
        stream(10, 14, stalls);
        check("tail_stalls", 32'(stalls), 32'd0);
        check("tail_enc_count", 32'(enc_count), 32'd15);
        check("tail_err_count", 32'(err_count), 32'd6);
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third held off until the buffer drains
        bus.out_ready = 1'b0;
        p0 = pop_cnt;
        send(vec[1], stalls);
        check("bp_first_stalls", 32'(stalls), 32'd0);
        send(vec[6], stalls);
        check("bp_second_stalls", 32'(stalls), 32'd0);
        check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        drive(vec[7]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_head_hold", 32'(bus.out_instr), 32'(vec[1].exp_instr));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        c_acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(bus.out_valid), 32'd1);
            if (bus.in_valid && bus.in_ready) c_acc = 1'b1;
            @(posedge clk);
            #1;
            if (c_acc) bus.in_valid = 1'b0;
        end
        check("bp_third_accepted", 32'(c_acc), 32'd1);
        check("bp_pops", 32'(pop_cnt - p0), 32'd3);
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // clr_cnt concurrent with an accepted push
        drive(vec[2]);
        clr_cnt = 1'b1;
        @(negedge clk);
        check("clr_push_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr_cnt = 1'b0;
        check("clr_enc_count", 32'(enc_count), 32'd0);
        check("clr_err_count", 32'(err_count), 32'd0);
        send(vec[4], stalls);
        check("post_clr_enc_count", 32'(enc_count), 32'd1);
        check("post_clr_err_count", 32'(err_count), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset with two words buffered
        bus.out_ready = 1'b0;
        send(vec[3], stalls);
        send(vec[5], stalls);
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_instr", 32'(bus.out_instr), 32'd0);
        check("midrst_enc_count", 32'(enc_count), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_still_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        send(vec[11], stalls);
        check("after_rst_enc_count", 32'(enc_count), 32'd1);

        // Drain whatever is left, bounded
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
        #1;
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a 32-bit immediate, an ImmSrc type and a 25-bit instruction template, and scatters the immediate into instruction bits [31:7].
- Non-immediate template bits (rd, rs1, rs2, funct3) pass through unchanged.
- Flags immediates that are not encodable for the selected format.
- Used by the self-check/program-loader path; buffered with valid/ready handshakes on both sides.

Parameters:
- CNT_W, 16, width of the saturating statistics counters enc_count and err_count.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  buffer can accept a request
- imm  input  32  immediate value to encode (two's complement)
- ImmSrc  input  2  format: 00 I, 01 S, 10 B, 11 J
- templ  input  25  instruction bits [31:7] supplying non-immediate fields
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  25  encoded instruction bits [31:7]
- out_err  output  1  immediate not encodable for the format
- clr_cnt  input  1  synchronous clear of both counters
- enc_count  output  CNT_W  accepted requests, saturating
- err_count  output  CNT_W  accepted requests with out_err=1, saturating

Behaviour:
- Reset (async, active-high): buffer empty, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0. in_ready=1 as soon as reset deasserts.
- Packing, combinational before buffering; unlisted bits are taken from templ:
  - I: out[31:20]=imm[11:0].
  - S: out[31:25]=imm[11:5], out[11:7]=imm[4:0].
  - B: out[31]=imm[12], out[30:25]=imm[10:5], out[11:8]=imm[4:1], out[7]=imm[11].
  - J: out[31]=imm[20], out[30:21]=imm[10:1], out[20]=imm[11], out[19:12]=imm[19:12].
- Error rules:
  - I/S: err unless imm in [-2048, 2047].
  - B: err unless imm in [-4096, 4094] and imm[0]=0.
  - J: err unless imm in [-1048576, 1048574] and imm[0]=0.
  - On error the word is still packed with the truncated bits shown above.
- Buffer: 2-entry FIFO (skid) holding {out_instr, out_err}.
  - in_ready = (occupancy < 2). It is a function of occupancy only, never of out_ready.
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - out_valid = (occupancy > 0). out_instr/out_err show the head entry, and hold stable while out_valid=1 and out_ready=0.
  - Latency: a request accepted in cycle N appears at the outputs in cycle N+1 if the buffer was empty.
  - Simultaneous push and pop at occupancy 1: occupancy stays 1, the new entry becomes head next cycle.
  - At occupancy 2 no push is possible; a pop alone frees one slot.
  - Order is strictly FIFO.
  - When empty, out_instr/out_err hold their last values; content is don't-care while out_valid=0.
- Counters:
  - enc_count +1 per push; err_count +1 per push with err=1.
  - Both saturate at all-ones.
  - clr_cnt zeroes both and takes priority over an increment in the same cycle. It does not affect the buffer.
- Reset mid-operation: buffered words are discarded, outputs return to reset values immediately.

Decomposition:
- Package riscv_imm_pkg:
  - ImmSrc constants IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11.
  - Range limit constants for each format.
  - Shared with the extender.
- One combinational sub-module imm_pack (imm, ImmSrc, templ -> packed, err).
- The top level holds the 2-entry FIFO, handshakes and counters.

Test Plan:
- I-type, imm=-1, templ=0: after one cycle, out_instr[24:13]=12'hFFF (bits 31:20), err=0. Feeding {out_instr} to the extender returns 32'hFFFFFFFF.
- B-type, imm=-4096: out bit31=1, bits[30:25]=0, bits[11:8]=0, bit7=0, err=0. B-type imm=3 (odd) -> err=1, err_count=1.
- J-type, imm=1048576: err=1. J-type imm=1048574 -> err=0, and the extender round-trip equals the input.
- Backpressure: hold out_ready=0 and push 3 requests. Only 2 are accepted, in_ready=0 after the 2nd. Release out_ready and the words drain in order, one per cycle.
- Simultaneous push and pop at occupancy 1 over 10 back-to-back requests with out_ready=1: throughput of one word per cycle, enc_count=10.
- Assert reset with 2 entries buffered: out_valid=0 immediately, counters=0, in_ready=1 after release. clr_cnt concurrent with an accepted push -> counters read 0.
